// File: rtl/instr_buffer_pkg.sv
// Shared fetch/decode instruction types and instruction-buffer defaults.
package instr_buffer_pkg;

    localparam int PC_W               = 32;
    localparam int INSTR_W            = 32;
    localparam int INSTR_BUFFER_DEPTH = 16;

    typedef struct packed {
        logic               valid;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } instr_buffer_info_t;

endpackage

// File: rtl/instr_buffer_chk.sv
// Overflow checker for instr_buffer: a push must never exceed the free slots.
module instr_buffer_chk
    import instr_buffer_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int DEPTH       = INSTR_BUFFER_DEPTH,
    parameter int PW          = $clog2(DEPTH) + 1
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   flush,
    input logic [FETCH_WIDTH-1:0] valid,
    input logic [PW-1:0]          count
);

    logic [PW-1:0] push_cnt_s;

    // Number of lanes the buffer is asked to accept this cycle.
    always_comb begin
        push_cnt_s = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (valid[i]) begin
                push_cnt_s = push_cnt_s + PW'(1'b1);
            end else begin
                push_cnt_s = push_cnt_s;
            end
        end
    end

    // Flag a push that would overrun the remaining capacity.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (push_cnt_s <= (PW'(DEPTH) - count))
            else $error("FAIL overflow: push %0d with count %0d", push_cnt_s, count);
        end
    end

endmodule

// File: rtl/instr_buffer.sv
// Fetch-to-decode decoupling FIFO: compacts up to FETCH_WIDTH valid lanes per cycle
// and issues up to DECODE_WIDTH oldest entries per cycle on a registered output.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = INSTR_BUFFER_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  instr_buffer_info_t [FETCH_WIDTH-1:0]   frontend_instr_i,
    output logic                                   frontend_stallreq_o,
    input  logic                                   backend_flush_i,
    input  logic                                   decode_stallreq_i,
    output instr_buffer_info_t [DECODE_WIDTH-1:0]  decode_instr_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] MARGIN_P = PW'(2 * FETCH_WIDTH);
    localparam logic [PW-1:0] DW_P     = PW'(DECODE_WIDTH);

    instr_buffer_info_t                    mem_r [DEPTH];
    instr_buffer_info_t [DECODE_WIDTH-1:0] out_r;
    instr_buffer_info_t [DECODE_WIDTH-1:0] out_next_s;

    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [PW-1:0] count_r;
    logic [PW-1:0] push_cnt_s;
    logic [PW-1:0] pop_cnt_s;
    logic [PW-1:0] head_next_s;
    logic [PW-1:0] tail_next_s;
    logic [PW-1:0] count_next_s;
    logic [IW-1:0] wr_idx_s [FETCH_WIDTH];
    logic          wr_en_s  [FETCH_WIDTH];
    logic          stall_r;

    // Compact valid fetch lanes into consecutive slots starting at tail.
    always_comb begin
        push_cnt_s = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_idx_s[i] = IW'(tail_r + push_cnt_s);
            wr_en_s[i]  = frontend_instr_i[i].valid;
            if (frontend_instr_i[i].valid) begin
                push_cnt_s = push_cnt_s + PW'(1'b1);
            end else begin
                push_cnt_s = push_cnt_s;
            end
        end
    end

    // Select up to DECODE_WIDTH oldest entries from pre-push contents.
    always_comb begin
        pop_cnt_s  = '0;
        out_next_s = '0;
        if (decode_stallreq_i) begin
            pop_cnt_s = '0;
        end else if (count_r < DW_P) begin
            pop_cnt_s = count_r;
        end else begin
            pop_cnt_s = DW_P;
        end
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (PW'(i) < pop_cnt_s) begin
                out_next_s[i]       = mem_r[IW'(head_r + PW'(i))];
                out_next_s[i].valid = 1'b1;
            end else begin
                out_next_s[i] = '0;
            end
        end
    end

    assign tail_next_s  = tail_r + push_cnt_s;
    assign head_next_s  = head_r + pop_cnt_s;
    assign count_next_s = tail_next_s - head_next_s;

    // Storage write; discarded input during reset or flush never lands.
    always_ff @(posedge clk) begin
        if (!rst && !backend_flush_i) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (wr_en_s[i]) begin
                    mem_r[wr_idx_s[i]] <= frontend_instr_i[i];
                end
            end
        end
    end

    // Pointer, occupancy, output and stall registers; flush behaves as a soft reset.
    always_ff @(posedge clk) begin
        if (rst || backend_flush_i) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            out_r   <= '0;
            stall_r <= 1'b0;
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
            if (!decode_stallreq_i) begin
                out_r <= out_next_s;
            end
            // Stall tracks the registered count, leaving room for one in-flight group.
            stall_r <= (DEPTH_P - count_next_s) < MARGIN_P;
        end
    end

    assign frontend_stallreq_o = stall_r;
    assign decode_instr_o      = out_r;

endmodule

// File: tb/tb_instr_buffer.sv
// Directed self-checking bench for instr_buffer (FETCH_WIDTH=2, DECODE_WIDTH=2, DEPTH=16).
module tb_instr_buffer;
    import instr_buffer_pkg::*;

    typedef instr_buffer_info_t [1:0] grp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic dstall;
    logic fstall;
    grp_t fin;
    grp_t dout;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] pc;
    logic [31:0] exp_pc;
    grp_t        zg;

    always #5 clk = ~clk;

    instr_buffer #(.FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .frontend_instr_i    (fin),
        .frontend_stallreq_o (fstall),
        .backend_flush_i     (flush),
        .decode_stallreq_i   (dstall),
        .decode_instr_o      (dout)
    );

    instr_buffer_chk #(.FETCH_WIDTH(2), .DEPTH(16)) chk (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .valid ({fin[1].valid, fin[0].valid}),
        .count (dut.count_r)
    );

    function automatic instr_buffer_info_t mk(input logic [31:0] p);
        instr_buffer_info_t e;
        e.valid = 1'b1;
        e.pc    = p;
        e.instr = p ^ 32'h5a5a_0013;
        return e;
    endfunction

    function automatic grp_t grp2(input logic [31:0] p);
        grp_t g;
        g[0] = mk(p);
        g[1] = mk(p + 32'd4);
        return g;
    endfunction

    function automatic grp_t grp1(input logic [31:0] p);
        grp_t g;
        g[0] = mk(p);
        g[1] = '0;
        return g;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input grp_t exp);
        compared++;
        assert (dout === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, dout, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Push one full group per cycle with decode never stalling; each group appears two edges later.
    task automatic stream(input logic [31:0] base, input int n, input string tag);
        for (int k = 0; k <= n + 1; k++) begin
            if (k < n) fin = grp2(base + 32'(8 * k));
            else       fin = '0;
            step();
            if (k == 0 || k == n + 1) check_out({tag, "_empty"}, zg);
            else                      check_out(tag, grp2(base + 32'(8 * (k - 1))));
        end
        check_val({tag, "_count"}, 32'(dut.count_r), 32'd0);
    endtask

    initial begin
        zg     = '0;
        rst    = 1'b1;
        flush  = 1'b0;
        dstall = 1'b0;
        fin    = '0;

        // Reset
        step();
        step();
        check_out("rst_out", zg);
        check_val("rst_stall", 32'(fstall), 32'd0);
        check_val("rst_count", 32'(dut.count_r), 32'd0);
        rst = 1'b0;

        // Streaming, order kept over 20 groups
        stream(32'h1c00_0000, 20, "stream");

        // Fill while decode stalls: single lane, then pairs until stall rises at 13
        dstall = 1'b1;
        fin    = grp1(32'h1c00_0200);
        step();
        check_val("fill_count1", 32'(dut.count_r), 32'd1);
        check_val("fill_stall1", 32'(fstall), 32'd0);
        pc = 32'h1c00_0204;
        for (int j = 1; j <= 6; j++) begin
            fin = grp2(pc);
            pc  = pc + 32'd8;
            step();
            check_val("fill_count", 32'(dut.count_r), 32'(1 + 2 * j));
            check_val("fill_stall", 32'(fstall), (j == 6) ? 32'd1 : 32'd0);
        end
        fin = grp2(pc);
        step();
        check_val("inflight_count", 32'(dut.count_r), 32'd15);
        check_val("inflight_stall", 32'(fstall), 32'd1);
        fin = '0;
        step();
        check_val("hold_count", 32'(dut.count_r), 32'd15);
        check_out("fill_out_held", zg);

        // Drain 15 entries two at a time, with a stall window, ending in a partial pop
        dstall = 1'b0;
        exp_pc = 32'h1c00_0200;
        for (int p = 0; p < 7; p++) begin
            step();
            check_out("drain", grp2(exp_pc));
            exp_pc = exp_pc + 32'd8;
            if (p == 1) begin
                dstall = 1'b1;
                step();
                step();
                check_out("drain_held", grp2(exp_pc - 32'd8));
                check_val("drain_held_count", 32'(dut.count_r), 32'd11);
                dstall = 1'b0;
            end
        end
        check_val("drain_stall_low", 32'(fstall), 32'd0);
        step();
        check_out("partial_pop", grp1(exp_pc));
        check_val("partial_count", 32'(dut.count_r), 32'd0);
        step();
        check_out("drained_empty", zg);

        // Wrap: 40 cycles of push/pop through a 16-entry buffer
        stream(32'h1c00_0400, 40, "wrap");

        // Flush with count=8 and a live output
        dstall = 1'b1;
        pc     = 32'h1c00_0800;
        for (int j = 0; j < 4; j++) begin
            fin = grp2(pc);
            pc  = pc + 32'd8;
            step();
        end
        dstall = 1'b0;
        fin    = grp2(pc);
        step();
        check_val("preflush_count", 32'(dut.count_r), 32'd8);
        check_out("preflush_out", grp2(32'h1c00_0800));
        flush = 1'b1;
        fin   = grp2(32'h1c00_09f0);
        step();
        check_out("flush_out", zg);
        check_val("flush_count", 32'(dut.count_r), 32'd0);
        check_val("flush_stall", 32'(fstall), 32'd0);
        flush = 1'b0;
        fin   = grp2(32'h1c00_0100);
        step();
        check_out("postflush_first_empty", zg);
        fin = '0;
        step();
        check_out("postflush_first", grp2(32'h1c00_0100));
        step();
        check_out("postflush_empty", zg);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
